led_pio_arbiter: RTL and testbench

//   Shares the single Green LEDs PIO slave (s1: address/chipselect/write_n/writedata/readdata) between two
//   on-chip requesters: req0 = HPS-side control logic, req1 = hardware audio level meter.

---
 rtl/led_pio_arbiter.sv | 132 +++++++++++++
 tb/tb_led_pio_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pio_arbiter.sv
// Round-robin arbiter sharing the Green LEDs PIO slave between two requesters.
// One PIO access per grant, request/ack handshake, per-requester readback of LED state.
module led_pio_arbiter #(
    parameter int DATA_W   = 9,
    parameter int PIO_ADDR = 0,
    parameter int MIN_GAP  = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              rnw0,
    input  logic              rnw1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [1:0]        pio_address,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [31:0]       pio_writedata,
    input  logic [31:0]       pio_readdata,
    output logic [1:0]        fsm_state
);

    // Handshake: a requester raises reqN with rnwN/wdataN stable and holds it
    // until ackN pulses for one cycle; reqN must be low in the cycle after ackN.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LOAD = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;

    state_t      state, state_nxt;
    logic [3:0]  gap_cnt, gap_cnt_nxt;
    logic        owner;
    logic        last_grant;
    logic        rnw_q;
    logic        take;
    logic        win;
    logic        win_rnw;
    logic [DATA_W-1:0] win_wdata;
    logic        unused_readdata;

    assign unused_readdata = ^pio_readdata[31:DATA_W];

    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        take        = 1'b0;
        win         = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    take      = 1'b1;
                    state_nxt = ACCESS;
                    // On a tie the requester that did not win last time goes first.
                    win       = (req0 && req1) ? ~last_grant : req1;
                end
            end
            ACCESS: state_nxt = DONE;
            DONE: begin
                if (MIN_GAP > 0) begin
                    state_nxt   = GAP;
                    gap_cnt_nxt = GAP_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) state_nxt = IDLE;
                else                 gap_cnt_nxt = gap_cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign win_rnw   = win ? rnw1 : rnw0;
    assign win_wdata = win ? wdata1 : wdata0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            gap_cnt        <= 4'd0;
            owner          <= 1'b0;
            last_grant     <= 1'b1;
            rnw_q          <= 1'b1;
            grant          <= 2'b00;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= 32'd0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
            ack0    <= (state == ACCESS) && !owner;
            ack1    <= (state == ACCESS) && owner;
            if (take) begin
                owner          <= win;
                last_grant     <= win;
                rnw_q          <= win_rnw;
                grant          <= win ? 2'b10 : 2'b01;
                pio_chipselect <= 1'b1;
                pio_write_n    <= win_rnw;
                pio_writedata  <= {{(32-DATA_W){1'b0}}, win_wdata};
            end
            if (state == ACCESS) begin
                pio_chipselect <= 1'b0;
                pio_write_n    <= 1'b1;
                // The slave answers combinationally, so readdata is valid at this edge.
                if (rnw_q && !owner) rdata0 <= pio_readdata[DATA_W-1:0];
                if (rnw_q && owner)  rdata1 <= pio_readdata[DATA_W-1:0];
            end
            if (state == DONE) grant <= 2'b00;
        end
    end

    assign busy        = (state != IDLE);
    assign pio_address = 2'(PIO_ADDR);
    assign fsm_state   = state;

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Bench for led_pio_arbiter: directed vector table, tie/gap/reset sequences,
// and two random requesters checked against a PIO model and write scoreboard.
module tb_led_pio_arbiter;

    localparam int W = 9;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, req1, rnw0, rnw1;
    logic [W-1:0]  wdata0, wdata1;
    logic          ack0, ack1;
    logic [W-1:0]  rdata0, rdata1;
    logic [1:0]    grant;
    logic          busy;
    logic [1:0]    pio_address;
    logic          pio_chipselect, pio_write_n;
    logic [31:0]   pio_writedata, pio_readdata;
    logic [1:0]    fsm_state;
    logic [W-1:0]  pio_led;

    logic          g_req0, g_req1;
    logic          g_ack0, g_ack1;
    logic [W-1:0]  g_rdata0, g_rdata1;
    logic [1:0]    g_grant;
    logic          g_busy;
    logic [1:0]    g_pio_address;
    logic          g_cs, g_write_n;
    logic [31:0]   g_writedata, g_readdata;
    logic [1:0]    g_fsm_state;
    logic [W-1:0]  g_led;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    led_pio_arbiter #(.DATA_W(W), .PIO_ADDR(0), .MIN_GAP(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .rnw0(rnw0), .rnw1(rnw1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .grant(grant), .busy(busy), .pio_address(pio_address),
        .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
        .pio_writedata(pio_writedata), .pio_readdata(pio_readdata),
        .fsm_state(fsm_state)
    );

    led_pio_arbiter #(.DATA_W(W), .PIO_ADDR(0), .MIN_GAP(3)) dut_gap (
        .clk(clk), .reset_n(reset_n),
        .req0(g_req0), .req1(g_req1), .rnw0(1'b0), .rnw1(1'b0),
        .wdata0(9'h011), .wdata1(9'h022),
        .ack0(g_ack0), .ack1(g_ack1), .rdata0(g_rdata0), .rdata1(g_rdata1),
        .grant(g_grant), .busy(g_busy), .pio_address(g_pio_address),
        .pio_chipselect(g_cs), .pio_write_n(g_write_n),
        .pio_writedata(g_writedata), .pio_readdata(g_readdata),
        .fsm_state(g_fsm_state)
    );

    // PIO slave models: one data register, reset by the shared reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pio_led <= '0;
        else if (pio_chipselect && !pio_write_n && pio_address == 2'd0)
            pio_led <= pio_writedata[W-1:0];
    end
    assign pio_readdata = {23'd0, pio_led};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) g_led <= '0;
        else if (g_cs && !g_write_n) g_led <= g_writedata[W-1:0];
    end
    assign g_readdata = {23'd0, g_led};

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic access(input int who, input logic rnw, input logic [W-1:0] wd,
                          input logic [W-1:0] exp_rd, input string tag);
        if (who == 0) begin rnw0 = rnw; wdata0 = wd; req0 = 1'b1; end
        else          begin rnw1 = rnw; wdata1 = wd; req1 = 1'b1; end
        @(negedge clk);
        check({tag, "_cs"}, pio_chipselect, 1);
        check({tag, "_write_n"}, pio_write_n, rnw);
        if (!rnw) check({tag, "_writedata"}, pio_writedata, {23'd0, wd});
        check({tag, "_grant"}, grant, (who == 0) ? 2'b01 : 2'b10);
        @(negedge clk);
        check({tag, "_ack"}, {ack1, ack0}, (who == 0) ? 2'b01 : 2'b10);
        check({tag, "_rdata"}, (who == 0) ? rdata0 : rdata1, exp_rd);
        check({tag, "_cs_low"}, pio_chipselect, 0);
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, {busy, ack1, ack0}, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- scoreboard for random traffic ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_wr;
    logic         rand_en = 1'b0;
    logic         pend0 = 1'b0, pend1 = 1'b0;
    int           n_req0 = 0, n_req1 = 0, n_ack0 = 0, n_ack1 = 0;

    always @(posedge clk) begin
        #1;
        if (rand_en) begin
            check("rand_ack_exclusive", ack0 & ack1, 0);
            if (pio_chipselect && !pio_write_n) exp_q.push_back(pio_writedata[W-1:0]);
            if (ack0) begin n_ack0++; check("rand_ack0_requested", pend0, 1); end
            if (ack1) begin n_ack1++; check("rand_ack1_requested", pend1, 1); end
        end
    end

    task automatic drive(input int who, input int n);
        logic         rnw;
        logic [W-1:0] wd;
        logic         got;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rnw = 1'($urandom_range(0, 1));
            wd  = W'($urandom_range(0, 511));
            if (who == 0) begin pend0 = 1'b1; rnw0 = rnw; wdata0 = wd; req0 = 1'b1; n_req0++; end
            else          begin pend1 = 1'b1; rnw1 = rnw; wdata1 = wd; req1 = 1'b1; n_req1++; end
            got = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if ((who == 0 && ack0) || (who == 1 && ack1)) begin got = 1'b1; break; end
            end
            check("rand_ack_in_time", got, 1);
            if (got) begin
                if (rnw) begin
                    check("rand_read_data", (who == 0) ? rdata0 : rdata1, last_wr);
                end else begin
                    last_wr = wd;
                    check("rand_pio_value", pio_led, wd);
                    check("rand_write_seen", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("rand_write_data", exp_q.pop_front(), wd);
                end
            end
            if (who == 0) begin req0 = 1'b0; pend0 = 1'b0; end
            else          begin req1 = 1'b0; pend1 = 1'b0; end
            if (!got) return;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int           who;
        logic         rnw;
        logic [W-1:0] wdata;
        logic [W-1:0] exp_rdata;
        logic [W-1:0] exp_led;
    } vec_t;

    vec_t vecs[9];
    int   glog[8];
    int   n_g, p1, p2, first_c;
    logic busy_log[32];

    initial begin
        vecs[0] = '{0, 1'b0, 9'h0FF, 9'h000, 9'h0FF};
        vecs[1] = '{1, 1'b1, 9'h000, 9'h0FF, 9'h0FF};
        vecs[2] = '{1, 1'b0, 9'h155, 9'h0FF, 9'h155};
        vecs[3] = '{0, 1'b1, 9'h000, 9'h155, 9'h155};
        vecs[4] = '{0, 1'b0, 9'h1FF, 9'h155, 9'h1FF};
        vecs[5] = '{1, 1'b1, 9'h000, 9'h1FF, 9'h1FF};
        vecs[6] = '{0, 1'b1, 9'h000, 9'h1FF, 9'h1FF};
        vecs[7] = '{1, 1'b0, 9'h000, 9'h1FF, 9'h000};
        vecs[8] = '{0, 1'b1, 9'h000, 9'h000, 9'h000};

        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; rnw0 = 1'b0; rnw1 = 1'b0;
        wdata0 = '0; wdata1 = '0; g_req0 = 1'b0; g_req1 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_grant", grant, 0);
        check("rst_acks", {ack1, ack0}, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_cs", pio_chipselect, 0);
        check("rst_write_n", pio_write_n, 1);
        check("rst_writedata", pio_writedata, 0);
        check("rst_busy", busy, 0);
        check("rst_address", pio_address, 0);
        check("rst_state", fsm_state, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Write then cross-requester readback
        access(0, 1'b0, 9'h1A5, 9'h000, "t1_write");
        check("t1_led", pio_led, 9'h1A5);
        access(1, 1'b1, 9'h000, 9'h1A5, "t2_read");
        check("t2_rdata0_kept", rdata0, 9'h000);

        foreach (vecs[i]) begin
            access(vecs[i].who, vecs[i].rnw, vecs[i].wdata, vecs[i].exp_rdata,
                   $sformatf("vec%0d", i));
            check($sformatf("vec%0d_led", i), pio_led, vecs[i].exp_led);
        end

        // Tie from reset, then alternation with both held
        do_reset();
        rnw0 = 1'b1; rnw1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        n_g = 0; first_c = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (pio_chipselect) begin
                if (first_c < 0) first_c = c;
                if (n_g < 8) glog[n_g] = int'(grant);
                n_g++;
            end
            if (ack1 && n_g >= 4) req1 = 1'b0;
            if (ack0 && n_g >= 5) begin req0 = 1'b0; break; end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check("t3_first_latency", first_c, 1);
        check("t3_grant_count", n_g, 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("t3_grant%0d", i), glog[i], (i % 2 == 0) ? 1 : 2);

        // MIN_GAP=3 build: back-to-back accesses
        g_req0 = 1'b1; g_req1 = 1'b1;
        p1 = -1; p2 = -1;
        for (int c = 1; c < 32; c++) begin
            @(negedge clk);
            busy_log[c] = g_busy;
            if (g_cs) begin
                if (p1 < 0) p1 = c;
                else if (p2 < 0) p2 = c;
            end
            if (g_ack0) g_req0 = 1'b0;
            if (g_ack1) g_req1 = 1'b0;
        end
        check("t4_first_cs", p1, 1);
        check("t4_cs_spacing", p2 - p1, 6);
        if (p1 > 0 && p1 < 26) begin
            for (int c = p1 + 1; c <= p1 + 4; c++)
                check($sformatf("t4_busy_c%0d", c), busy_log[c], 1);
            check("t4_idle_before_next", busy_log[p1 + 5], 0);
        end
        check("t4_led", g_led, 9'h022);

        // Reset in the middle of an access
        rnw0 = 1'b0; wdata0 = 9'h0AA; req0 = 1'b1;
        @(negedge clk);
        check("t5_cs_before", pio_chipselect, 1);
        reset_n = 1'b0;
        #1;
        check("t5_cs_dropped", pio_chipselect, 0);
        check("t5_write_n", pio_write_n, 1);
        check("t5_busy", busy, 0);
        req0 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("t5_no_ack_in_reset", {ack1, ack0}, 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("t5_no_ack_after", {ack1, ack0}, 0);
        check("t5_state_idle", fsm_state, 0);
        check("t5_led_cleared", pio_led, 0);
        access(1, 1'b1, 9'h000, 9'h000, "t5_read");

        // Random two-requester traffic
        last_wr = pio_led;
        rand_en = 1'b1;
        fork
            drive(0, 1500);
            drive(1, 1500);
        join
        repeat (4) @(negedge clk);
        rand_en = 1'b0;
        check("rand_acks0", n_ack0, n_req0);
        check("rand_acks1", n_ack1, n_req1);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
